// File: rtl/pad_cfg_serial_loader.sv
// Shadow configuration store for the user pad ring plus the serial engine that
// shifts every pad word into the daisy-chained pad control registers and strobes a common load.
module pad_cfg_serial_loader #(
  parameter int                  NUM_PADS    = 38,
  parameter int                  CFG_BITS    = 13,
  parameter int                  CLK_DIV     = 4,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 13'h0403,
  parameter bit                  AUTO_START  = 1'b1,
  localparam int                 AW          = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CFG_BITS-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [CFG_BITS-1:0] rd_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                wr_err,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load
);

  localparam int TOTAL = NUM_PADS * CFG_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Handshake: a write is taken on any edge where wr_en=1, busy=0 and the address
  // is in range; start is a one-cycle request honoured only while busy=0, and busy
  // stays high from the first SHIFT cycle until done pulses on return to IDLE.
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, HOLD} state_t;

  state_t              state;
  logic [CFG_BITS-1:0] shadow [NUM_PADS];
  logic [TOTAL-1:0]    flat;
  logic [CW-1:0]       bit_cnt;
  logic [DW-1:0]       div_cnt;
  logic                phase;
  logic                auto_pend;
  logic                addr_ok;
  logic                wr_ok;
  logic                launch;
  logic                first_bit;
  logic                next_bit;
  logic                last_div;
  logic                last_bit;

  assign addr_ok  = int'(wr_addr) < NUM_PADS;
  assign wr_ok    = wr_en && !busy && addr_ok;
  assign launch   = (state == IDLE) && (start || auto_pend);
  assign last_div = div_cnt == DW'(CLK_DIV - 1);
  assign last_bit = bit_cnt == CW'(TOTAL - 1);
  assign rd_data  = (int'(rd_addr) < NUM_PADS) ? shadow[rd_addr] : '0;

  // Pad k occupies flat[k*CFG_BITS +: CFG_BITS], so the stream is simply flat MSB down.
  always_comb begin
    flat = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      flat[k*CFG_BITS +: CFG_BITS] = shadow[k];
    end
  end

  always_comb begin
    next_bit = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      if (i == TOTAL - 2 - int'(bit_cnt)) next_bit = flat[i];
    end
  end

  // A write landing in the launch cycle must already be visible in the first bit.
  assign first_bit = (wr_ok && int'(wr_addr) == NUM_PADS - 1) ? wr_data[CFG_BITS-1]
                                                              : shadow[NUM_PADS-1][CFG_BITS-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_PADS; k++) shadow[k] <= DEFAULT_CFG;
      wr_err <= 1'b0;
    end else begin
      if (wr_ok) shadow[wr_addr] <= wr_data;
      wr_err <= wr_en && (busy || !addr_ok);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      phase        <= 1'b0;
      auto_pend    <= AUTO_START;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          auto_pend <= 1'b0;
          if (launch) begin
            state        <= SHIFT;
            busy         <= 1'b1;
            serial_data  <= first_bit;
            serial_clock <= 1'b0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            phase        <= 1'b0;
          end
        end
        SHIFT: begin
          if (!last_div) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!phase) begin
              phase        <= 1'b1;
              serial_clock <= 1'b1;
            end else begin
              phase        <= 1'b0;
              serial_clock <= 1'b0;
              if (last_bit) begin
                state       <= LOAD;
                serial_data <= 1'b0;
                serial_load <= 1'b1;
              end else begin
                bit_cnt     <= bit_cnt + 1'b1;
                serial_data <= next_bit;
              end
            end
          end
        end
        LOAD: begin
          if (!last_div) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt     <= '0;
            serial_load <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (!last_div) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
